// File: rtl/imem_ctrl_pkg.sv
// rtl/imem_ctrl_pkg.sv - shared state encoding, word size and address range check for imem_ctrl
// Contents: ST_* 2-bit controller states, WORD_BYTES, addr_faults() range/alignment test.
package imem_ctrl_pkg;

    localparam logic [1:0] ST_RESET = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_LOAD  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [31:0] WORD_BYTES = 32'd4;

    // A word access at addr is legal only if aligned and the whole word fits.
    // Comparing against (mem_bytes - 4) rather than computing addr + 4 keeps
    // addresses near 2^32 (e.g. 32'hFFFF_FFFC) from wrapping into range.
    function automatic logic addr_faults(input logic [31:0] addr, input logic [31:0] mem_bytes);
        return (addr[1:0] != 2'b00) || (addr > (mem_bytes - WORD_BYTES));
    endfunction

endpackage

// File: rtl/imem_fetch_reg.sv
// rtl/imem_fetch_reg.sv - fetched instruction output register (inst, inst_pc, inst_valid)
// Ports: clk, rst_n (async active-low); capture loads cap_inst/cap_pc and sets
// inst_valid; clear drops inst_valid (capture wins); inst/inst_pc/inst_valid outputs.
module imem_fetch_reg (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        capture,
    input  logic        clear,
    input  logic [31:0] cap_inst,
    input  logic [31:0] cap_pc,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_valid <= 1'b0;
            inst       <= 32'h0;
            inst_pc    <= 32'h0;
        end else if (capture) begin
            inst_valid <= 1'b1;
            inst       <= cap_inst;
            inst_pc    <= cap_pc;
        end else if (clear) begin
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/imem_ctrl.sv
// rtl/imem_ctrl.sv - instruction memory controller: sequential fetch, redirect, fault and loader write
// Ports: clk, rst_n (async active-low); fetch_en, redirect_valid/redirect_pc,
// id_ready -> inst_valid/inst/inst_pc, sticky fault; loader ld_valid/ld_ready/
// ld_addr/ld_data/ld_err; memory mem_addr/mem_we/mem_wdata, combinational mem_rdata.
module imem_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int          MEM_BYTES = 512,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_en,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic        fault,
    input  logic        ld_valid,
    output logic        ld_ready,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        ld_err,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam logic [31:0] MEM_SIZE = MEM_BYTES;

    logic [1:0]  state;
    logic [31:0] pc;
    logic        fault_q;
    logic        in_load;
    logic        pc_bad;
    logic        ld_bad;
    logic        redirect_bad;
    logic        fetch_try;
    logic        capture;
    logic        fault_hit;
    logic        clear;

    assign in_load      = (state == ST_LOAD);
    assign pc_bad       = addr_faults(pc, MEM_SIZE);
    assign ld_bad       = addr_faults(ld_addr, MEM_SIZE);
    assign redirect_bad = addr_faults(redirect_pc, MEM_SIZE);

    // A fetch is attempted only when nothing of higher priority (redirect,
    // loader takeover) is pending and the output register has room.
    assign fetch_try = (state == ST_FETCH) && !redirect_valid && !ld_valid && fetch_en
                       && (!inst_valid || id_ready);
    assign capture   = fetch_try && !pc_bad;
    assign fault_hit = fetch_try && pc_bad;

    // Outside FETCH the register is already empty; inside FETCH it empties on
    // redirect, loader entry, a fault, or consumption without a refill.
    assign clear = (state != ST_FETCH) || redirect_valid || ld_valid || fault_hit
                   || (!capture && id_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RESET;
            pc      <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            case (state)
                ST_RESET: begin
                    state <= ST_FETCH;
                    pc    <= RESET_PC;
                end
                ST_FETCH: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                    end else if (ld_valid) begin
                        state <= ST_LOAD;
                    end else if (fault_hit) begin
                        state   <= ST_FAULT;
                        fault_q <= 1'b1;
                    end else if (capture) begin
                        pc <= pc + WORD_BYTES;
                    end
                end
                ST_FAULT: begin
                    if (redirect_valid) begin
                        pc <= redirect_pc;
                        if (!redirect_bad) begin
                            state   <= ST_FETCH;
                            fault_q <= 1'b0;
                        end
                    end else if (ld_valid) begin
                        state   <= ST_LOAD;
                        fault_q <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // Redirects are deliberately ignored while the loader owns memory.
                    if (!ld_valid) begin
                        state <= ST_FETCH;
                        pc    <= RESET_PC;
                    end
                end
                default: state <= ST_RESET;
            endcase
        end
    end

    assign fault     = fault_q;
    assign ld_ready  = in_load;
    assign mem_we    = in_load && ld_valid && !ld_bad;
    assign ld_err    = in_load && ld_valid && ld_bad;
    assign mem_wdata = in_load ? ld_data : 32'h0;

    always_comb begin
        mem_addr = 32'h0;
        case (state)
            ST_LOAD:  mem_addr = ld_addr;
            ST_FETCH: mem_addr = pc;
            ST_FAULT: mem_addr = pc;
            default:  mem_addr = 32'h0;
        endcase
    end

    imem_fetch_reg u_fetch_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .capture    (capture),
        .clear      (clear),
        .cap_inst   (mem_rdata),
        .cap_pc     (pc),
        .inst_valid (inst_valid),
        .inst       (inst),
        .inst_pc    (inst_pc)
    );

endmodule

// File: tb/tb_imem_ctrl.sv
// tb/tb_imem_ctrl.sv - self-checking bench for imem_ctrl with behavioural model and directed vectors
module tb_imem_ctrl;

    localparam int M_RESET = 0;
    localparam int M_FETCH = 1;
    localparam int M_LOAD  = 2;
    localparam int M_FAULT = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_en = 1'b1;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b1;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
    logic        ld_valid = 1'b0;
    logic        ld_ready;
    logic [31:0] ld_addr = 32'h0;
    logic [31:0] ld_data = 32'h0;
    logic        ld_err;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int vectors = 0;
    int miscompares = 0;
    int wr_count = 0;

    logic [31:0] tb_mem [0:127];
    logic [31:0] mm [0:127];

    int          m_mode = M_RESET;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_inst = 32'h0;
    logic [31:0] m_ipc = 32'h0;
    bit          m_v = 1'b0;
    bit          m_f = 1'b0;

    always #5 clk = ~clk;

    imem_ctrl #(.MEM_BYTES(512), .RESET_PC(32'h0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .fault          (fault),
        .ld_valid       (ld_valid),
        .ld_ready       (ld_ready),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data),
        .ld_err         (ld_err),
        .mem_addr       (mem_addr),
        .mem_we         (mem_we),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata)
    );

    assign mem_rdata = (mem_addr < 32'd512) ? tb_mem[mem_addr[8:2]] : 32'h0;

    always @(posedge clk) begin
        if (mem_we) begin
            tb_mem[mem_addr[8:2]] <= mem_wdata;
            wr_count <= wr_count + 1;
        end
    end

    function automatic bit bad(input logic [31:0] a);
        return (a % 32'd4 != 32'd0) || (({32'd0, a} + 64'd4) > 64'd512);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: one transition per clock, reset asynchronously.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_mode = M_RESET; m_pc = 32'h0; m_v = 0; m_inst = 32'h0; m_ipc = 32'h0; m_f = 0;
        end else begin
            case (m_mode)
                M_RESET: begin m_mode = M_FETCH; m_pc = 32'h0; end
                M_FETCH: begin
                    if (redirect_valid) begin
                        m_pc = redirect_pc; m_v = 0;
                    end else if (ld_valid) begin
                        m_mode = M_LOAD; m_v = 0;
                    end else if (fetch_en && (!m_v || id_ready)) begin
                        if (bad(m_pc)) begin
                            m_mode = M_FAULT; m_f = 1; m_v = 0;
                        end else begin
                            m_inst = mm[m_pc / 4]; m_ipc = m_pc; m_v = 1; m_pc = m_pc + 32'd4;
                        end
                    end else if (id_ready) begin
                        m_v = 0;
                    end
                end
                M_FAULT: begin
                    if (redirect_valid) begin
                        m_pc = redirect_pc;
                        if (!bad(redirect_pc)) begin m_mode = M_FETCH; m_f = 0; end
                    end else if (ld_valid) begin
                        m_mode = M_LOAD; m_f = 0;
                    end
                end
                default: begin
                    if (!ld_valid) begin
                        m_mode = M_FETCH; m_pc = 32'h0;
                    end else if (!bad(ld_addr)) begin
                        mm[ld_addr / 4] = ld_data;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison against the model.
    initial forever begin
        bit in_ld;
        @(negedge clk);
        in_ld = (m_mode == M_LOAD);
        check("inst_valid", {31'd0, inst_valid}, {31'd0, m_v});
        check("fault", {31'd0, fault}, {31'd0, m_f});
        check("ld_ready", {31'd0, ld_ready}, {31'd0, in_ld});
        check("mem_we", {31'd0, mem_we}, {31'd0, in_ld && ld_valid && !bad(ld_addr)});
        check("ld_err", {31'd0, ld_err}, {31'd0, in_ld && ld_valid && bad(ld_addr)});
        if (m_v || !rst_n) begin
            check("inst", inst, m_inst);
            check("inst_pc", inst_pc, m_ipc);
        end
        if (in_ld && ld_valid && !bad(ld_addr)) begin
            check("mem_addr_wr", mem_addr, ld_addr);
            check("mem_wdata", mem_wdata, ld_data);
        end
        if (m_mode == M_FETCH) check("mem_addr_fetch", mem_addr, m_pc);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 128; k++) begin
            tb_mem[k] = 32'h1000_0000 + 32'(k);
            mm[k]     = 32'h1000_0000 + 32'(k);
        end
        tb_mem[0] = 32'h00100093; mm[0] = 32'h00100093;
        tb_mem[1] = 32'h00200113; mm[1] = 32'h00200113;
        tb_mem[2] = 32'h00300193; mm[2] = 32'h00300193;

        // Reset state
        step(); step();
        @(negedge clk);
        check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        check("rst_inst", inst, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_ld_ready", {31'd0, ld_ready}, 32'd0);

        // Reset release and first two fetches
        step(); rst_n = 1'b1;
        @(negedge clk); check("rel_valid0", {31'd0, inst_valid}, 32'd0);
        step(); @(negedge clk); check("first_cycle_valid0", {31'd0, inst_valid}, 32'd0);
        step(); @(negedge clk);
        check("f0_valid", {31'd0, inst_valid}, 32'd1);
        check("f0_inst", inst, 32'h00100093);
        check("f0_pc", inst_pc, 32'h0);
        step(); id_ready = 1'b0;
        @(negedge clk); check("f1_inst", inst, 32'h00200113); check("f1_pc", inst_pc, 32'h4);

        // Decode stall
        repeat (3) begin
            step(); @(negedge clk);
            check("stall_pc", inst_pc, 32'h4); check("stall_inst", inst, 32'h00200113);
        end
        step(); id_ready = 1'b1;
        @(negedge clk); check("stall_last_pc", inst_pc, 32'h4);
        step(); @(negedge clk); check("after_stall_pc", inst_pc, 32'h8); check("after_stall_inst", inst, 32'h00300193);

        // Redirect concurrent with id_ready
        step(); redirect_valid = 1'b1; redirect_pc = 32'h10;
        step(); redirect_valid = 1'b0;
        @(negedge clk); check("redir_kill", {31'd0, inst_valid}, 32'd0);
        step(); @(negedge clk); check("redir_pc", inst_pc, 32'h10); check("redir_inst", inst, 32'h10000004);

        // Faulting redirects
        step(); redirect_valid = 1'b1; redirect_pc = 32'h1FE;
        step(); redirect_valid = 1'b0;
        step(); @(negedge clk); check("fault_1fe", {31'd0, fault}, 32'd1); check("fault_1fe_v", {31'd0, inst_valid}, 32'd0);
        step(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        step(); redirect_pc = 32'h20;
        @(negedge clk); check("fault_200_stays", {31'd0, fault}, 32'd1);
        step(); redirect_valid = 1'b0;
        @(negedge clk); check("fault_cleared", {31'd0, fault}, 32'd0);
        step(); @(negedge clk); check("recover_pc", inst_pc, 32'h20); check("recover_inst", inst, 32'h10000008);
        step(); redirect_valid = 1'b1; redirect_pc = 32'h200;
        step(); redirect_valid = 1'b0;
        step(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk); check("fault_200_fetch", {31'd0, fault}, 32'd1);
        step(); redirect_valid = 1'b0;
        @(negedge clk); check("fault_wrap", {31'd0, fault}, 32'd1);

        // Loader from FAULT
        step(); ld_valid = 1'b1; ld_addr = 32'h8; ld_data = 32'hDEADBEEF;
        @(negedge clk); check("ld_entry_rdy", {31'd0, ld_ready}, 32'd0); check("ld_entry_we", {31'd0, mem_we}, 32'd0);
        step(); @(negedge clk);
        check("ld_we8", {31'd0, mem_we}, 32'd1); check("ld_addr8", mem_addr, 32'h8); check("ld_fault_clr", {31'd0, fault}, 32'd0);
        step(); ld_addr = 32'h200; ld_data = 32'h12345678;
        @(negedge clk); check("ld_err200", {31'd0, ld_err}, 32'd1); check("ld_we200", {31'd0, mem_we}, 32'd0);
        step(); ld_valid = 1'b0;
        @(negedge clk); check("ld_err_pulse_end", {31'd0, ld_err}, 32'd0);
        step(); @(negedge clk); check("ld_writes", 32'(wr_count), 32'd1);
        step(); @(negedge clk); check("restart_pc", inst_pc, 32'h0);
        step(); step(); @(negedge clk); check("loaded_pc", inst_pc, 32'h8); check("loaded_inst", inst, 32'hDEADBEEF);

        // Consume without refill
        step(); fetch_en = 1'b0;
        @(negedge clk); check("pre_consume_pc", inst_pc, 32'hC);
        step(); fetch_en = 1'b1; ld_valid = 1'b1; ld_addr = 32'h0; ld_data = 32'hAAAA5555;
        @(negedge clk); check("consume_clear", {31'd0, inst_valid}, 32'd0);

        // Reset during load
        step(); @(negedge clk); check("midld_we", {31'd0, mem_we}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_we", {31'd0, mem_we}, 32'd0);
        check("midrst_rdy", {31'd0, ld_ready}, 32'd0);
        check("midrst_addr", mem_addr, 32'h0);
        check("midrst_wdata", mem_wdata, 32'h0);
        check("midrst_inst_pc", inst_pc, 32'h0);
        step(); ld_valid = 1'b0;
        step(); rst_n = 1'b1;
        step(); step();
        @(negedge clk);
        check("post_rst_inst", inst, 32'h00100093);
        check("post_rst_mem0", tb_mem[0], 32'h00100093);
        check("post_rst_writes", 32'(wr_count), 32'd1);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/imem_ctrl.md
IMEM_CTRL -- requirements
Module: imem_ctrl

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 512, meaning instruction memory size in bytes.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning first fetch address after reset or after a load.
REQ-003 SHALL have ports: clk in 1, single clock; rst_n in 1, reset, asynchronous active-low.
REQ-004 SHALL have ports: fetch_en in 1, fetch permitted; redirect_valid in 1, branch/jump taken; redirect_pc in 32, redirect target.
REQ-005 SHALL have ports: id_ready in 1, decode accepts instruction; inst_valid out 1, inst holds a valid word; inst out 32, fetched word; inst_pc out 32, address of inst; fault out 1, sticky fetch-address fault.
REQ-006 SHALL have ports: ld_valid in 1, loader word offered; ld_ready out 1, loader word accepted; ld_addr in 32, byte address; ld_data in 32, word; ld_err out 1, one-cycle out-of-range/misaligned write pulse.
REQ-007 SHALL have ports: mem_addr out 32, memory byte address; mem_we out 1, word write strobe; mem_wdata out 32, write word; mem_rdata in 32, combinational read word {M[a],M[a+1],M[a+2],M[a+3]}.

Function
REQ-008 SHALL implement states RESET, FETCH, LOAD, FAULT; RESET moves to FETCH on the first clock after rst_n deasserts.
REQ-009 SHALL, in FETCH, drive mem_addr = pc and mem_we = 0.
REQ-010 SHALL capture an instruction when in FETCH, fetch_en=1, no redirect, and (inst_valid=0 or id_ready=1): inst<=mem_rdata, inst_pc<=pc, inst_valid<=1, pc<=pc+4. Latency 1 cycle from pc to inst.
REQ-011 SHALL, when inst_valid=1 and id_ready=0, hold inst, inst_pc, inst_valid and pc unchanged.
REQ-012 SHALL clear inst_valid when id_ready=1 consumes a word and no new capture occurs (fetch_en=0).
REQ-013 SHALL, on redirect_valid=1 in FETCH or FAULT, set pc<=redirect_pc and inst_valid<=0 in the same edge; redirect has priority over capture and over id_ready.
REQ-014 SHALL treat pc as faulting when pc[1:0]!=0 or pc+4 > MEM_BYTES; a capture attempt at a faulting pc moves to FAULT, sets fault=1, inst_valid=0, no pc advance.
REQ-015 SHALL remain in FAULT until a redirect to a non-faulting address (clears fault, returns to FETCH) or ld_valid (goes to LOAD, clears fault); a faulting redirect stays in FAULT.
REQ-016 SHALL leave FETCH or FAULT for LOAD when ld_valid=1 and redirect_valid=0, clearing inst_valid on that edge; loader is not accepted in the entry cycle.
REQ-017 SHALL, in LOAD, drive ld_ready=1, mem_addr=ld_addr, mem_wdata=ld_data, mem_we=ld_valid and address non-faulting (same rule as REQ-014, on ld_addr).
REQ-018 SHALL pulse ld_err for one cycle and suppress mem_we when an accepted loader word has a faulting address; ld_ready still completes the handshake.
REQ-019 SHALL exit LOAD to FETCH on the first cycle with ld_valid=0, setting pc<=RESET_PC; redirect_valid is ignored in LOAD.
REQ-020 SHALL hold ld_ready=0 outside LOAD and mem_we=0 outside LOAD.
REQ-021 SHALL wrap pc arithmetic modulo 2^32 before the range check (pc=32'hFFFF_FFFC faults).

Reset
REQ-022 SHALL, while rst_n=0, force state=RESET, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fault=0, ld_ready=0, ld_err=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-023 SHALL abort an in-progress load on reset with no further writes; words already written remain in memory.

Structure
REQ-024 SHALL place the state encoding (2-bit) and the word-size constant 4 in the shared core package.
REQ-025 SHALL implement the inst/inst_pc/inst_valid output register as one sub-module, imem_fetch_reg; all other logic resides in imem_ctrl.

Verification
REQ-026 SHALL cover reset release with memory words 0x00100093,0x00200113 at 0,4 -> inst_valid rises 1 cycle after RESET leaves, inst=0x00100093 inst_pc=0, then 0x00200113 inst_pc=4.
REQ-027 SHALL cover id_ready=0 for 3 cycles at inst_pc=4 -> inst, inst_pc unchanged; after release next inst_pc=8.
REQ-028 SHALL cover redirect_valid with redirect_pc=0x10 concurrent with id_ready=1 -> inst_valid=0 next cycle, then inst_pc=0x10.
REQ-029 SHALL cover redirect to 0x1FE and to 0x200 (MEM_BYTES=512) -> fault=1, inst_valid=0; redirect to 0x20 -> fault=0, inst_pc=0x20.
REQ-030 SHALL cover loader writing 0xDEADBEEF at 0x8 and 0x12345678 at 0x200 -> one mem_we for 0x8, ld_err pulse for 0x200, then fetch restarts at RESET_PC and inst_pc=8 shows 0xDEADBEEF.
REQ-031 SHALL cover rst_n asserted mid-load -> mem_we=0 immediately, all outputs at reset values.
